rasteriser_unit: RTL and testbench
==================================

Name: rasteriser_unit

Overview:
- Per-triangle scan-conversion controller in the SimpleGPU pixel pipeline; 640x480 frame.
- On an opcode, loads triangle vertices, scans the clamped bounding box, and tests each pixel against three edge functions.
- For each covered pixel, requests colour (get_rgba), then issues a pixel write (get_pixel) at linear address pixel_number.
- Sequences triangles until the last one, then raises frame_ready_o.

Parameters:
- H_RES, 640, horizontal resolution in pixels.
- V_RES, 480, vertical resolution in pixels; H_RES*V_RES must fit in 19 bits.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- opcode_received  in  1  start-of-frame draw command (level or pulse; sampled in IDLE)
- frame_ready  in  1  downstream has accepted the completed frame
- data_ready  in  1  requested vertex/texture/colour data is valid this cycle
- triangle_done  in  1  high means the triangle just finished was the last of the frame
- x1,y1,x2,y2,x3,y3  in  16 each  unsigned vertex coordinates, valid when data_ready in LOAD
- clear  out  1  one-cycle pulse clearing downstream pixel counter/buffer at frame start
- count_up  out  1  one-cycle pulse per pixel written (coincident with get_pixel)
- next_triangle  out  1  one-cycle pulse requesting the next triangle
- load_texture  out  1  held high while waiting for vertex/texture data
- get_rgba  out  1  held high while waiting for a pixel's colour
- get_pixel  out  1  one-cycle write strobe for pixel_number
- get_line  out  1  one-cycle pulse when the scan advances to the next row
- pixel_number  out  19  y*H_RES + x of the current pixel
- frame_ready_o  out  1  frame complete; held until frame_ready

Behaviour:
- Reset is synchronous: state goes to IDLE and all outputs and registers go to 0, including pixel_number. Reset in any state aborts the operation.
- IDLE: all strobes low. If opcode_received=1, go to CLEAR.
- CLEAR: clear=1 for exactly one cycle, then go to LOAD.
- LOAD: load_texture=1. On data_ready=1, latch the six coordinates and go to SETUP.
- SETUP (1 cycle):
  - xmin/xmax = min/max of x1..x3, clamped to [0,H_RES-1]; ymin/ymax likewise, clamped to [0,V_RES-1].
  - Compute signed area A = E(v1,v2,v3).
  - If A=0 (degenerate), go to TRI_END. Otherwise set x=xmin, y=ymin and go to TEST.
- Edge function: E(a,b,p) = (bx-ax)*(py-ay) - (by-ay)*(px-ax). Use 17-bit signed differences and at least 36-bit signed accumulation; no overflow is permitted.
- TEST (1 cycle):
  - pixel_number = y*H_RES + x.
  - The pixel is inside iff E(v1,v2,p), E(v2,v3,p) and E(v3,v1,p) all have the same sign as A or are 0. Edge pixels are included, and both windings are accepted.
  - Inside: go to FETCH. Outside: go to ADVANCE.
- FETCH: get_rgba=1, pixel_number held. On data_ready=1, go to WRITE.
- WRITE: get_pixel=1 and count_up=1 for one cycle, then go to ADVANCE.
- ADVANCE (1 cycle):
  - If x<xmax: x=x+1.
  - Else if y<ymax: x=xmin, y=y+1, get_line=1.
  - Else go to TRI_END.
  - Otherwise return to TEST.
- TRI_END: next_triangle=1 for one cycle.
  - If triangle_done=1 in this cycle, go to FRAME.
  - Else go to LOAD.
- FRAME: frame_ready_o=1 until frame_ready=1, then go to IDLE.
- opcode_received outside IDLE is ignored. data_ready outside LOAD/FETCH is ignored.
- A vertex outside the screen still participates in the edge tests; only the scan box is clamped.

Test Plan:
- Assert reset for 2 cycles with all inputs toggling -> all outputs 0, pixel_number=0, IDLE. Pulse opcode_received for 1 cycle -> clear pulses once, then load_texture=1.
- Load (0,0),(3,0),(0,3) with data_ready, supply data_ready each FETCH, triangle_done=1 -> exactly 10 get_pixel/count_up pulses at pixel_number 0,1,2,3,640,641,642,1280,1281,1920. get_line pulses 3 times, next_triangle once, then frame_ready_o=1 until frame_ready.
- Same triangle with reversed winding (0,0),(0,3),(3,0) -> identical 10 pixels.
- Degenerate (5,5),(10,10),(20,20) with triangle_done=0 -> no get_rgba, next_triangle pulse, return to LOAD with load_texture=1.
- Triangle (630,470),(700,470),(630,500) -> every pixel_number < 307200 and max x/y = 639/479. Last write is 479*640+639=307199 if covered.
- Assert reset while in FETCH -> next cycle get_rgba=0 and IDLE. A following opcode restarts with a clear pulse.

Source files
------------

// File: rtl/rasteriser_unit_if.sv
// Bus bundle between the rasteriser controller and the rest of the SimpleGPU pixel pipeline.
//   Requests into the rasteriser: opcode_received, frame_ready, data_ready, triangle_done,
//                                 vertex coordinates x1..y3 (valid with data_ready in LOAD).
//   Strobes out of the rasteriser: clear, count_up, next_triangle, load_texture, get_rgba,
//                                  get_pixel, get_line, frame_ready_o, pixel_number.
// master: the pipeline side driving requests; slave: the rasteriser itself.
interface rasteriser_unit_if;
   logic        opcode_received;
   logic        frame_ready;
   logic        data_ready;
   logic        triangle_done;
   logic [15:0] x1;
   logic [15:0] y1;
   logic [15:0] x2;
   logic [15:0] y2;
   logic [15:0] x3;
   logic [15:0] y3;

   logic        clear;
   logic        count_up;
   logic        next_triangle;
   logic        load_texture;
   logic        get_rgba;
   logic        get_pixel;
   logic        get_line;
   logic [18:0] pixel_number;
   logic        frame_ready_o;

   modport master (
      output opcode_received, frame_ready, data_ready, triangle_done,
      output x1, y1, x2, y2, x3, y3,
      input  clear, count_up, next_triangle, load_texture, get_rgba, get_pixel, get_line,
      input  pixel_number, frame_ready_o
   );

   modport slave (
      input  opcode_received, frame_ready, data_ready, triangle_done,
      input  x1, y1, x2, y2, x3, y3,
      output clear, count_up, next_triangle, load_texture, get_rgba, get_pixel, get_line,
      output pixel_number, frame_ready_o
   );
endinterface

// File: rtl/rasteriser_unit.sv
// Per-triangle scan-conversion controller.
// Loads three vertices, walks the screen-clamped bounding box one pixel at a time, tests each
// pixel against the three edge functions and, for covered pixels, fetches a colour and issues a
// write strobe at linear address y*H_RES + x. Triangles are sequenced until the last one of the
// frame, after which frame_ready_o is held until the downstream acknowledges.
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous active-high reset; aborts any operation
//   bus    - rasteriser_unit_if.slave: request inputs, vertex data and pipeline strobes
module rasteriser_unit #(
   parameter int unsigned H_RES = 640,
   parameter int unsigned V_RES = 480
) (
   input logic              clk,
   input logic              reset,
   rasteriser_unit_if.slave bus
);

   localparam logic [15:0] XLimit = 16'(H_RES - 1);
   localparam logic [15:0] YLimit = 16'(V_RES - 1);
   localparam logic [18:0] HResW  = 19'(H_RES);

   typedef enum logic [3:0] {
      StIdle,
      StClear,
      StLoad,
      StSetup,
      StTest,
      StFetch,
      StWrite,
      StAdvance,
      StTriEnd,
      StFrame
   } state_e;

   state_e state_q, state_d;

   logic [15:0] x1_q, y1_q, x2_q, y2_q, x3_q, y3_q;
   logic [15:0] xmin_q, xmax_q, ymin_q, ymax_q;
   logic [15:0] x_q, y_q;
   logic        area_neg_q;
   logic [18:0] pixel_number_q;

   function automatic logic [15:0] min3(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] c);
      logic [15:0] m;
      m = (a < b) ? a : b;
      return (m < c) ? m : c;
   endfunction

   function automatic logic [15:0] max3(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] c);
      logic [15:0] m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   function automatic logic [15:0] clamp(input logic [15:0] v, input logic [15:0] lim);
      return (v > lim) ? lim : v;
   endfunction

   // E(a,b,p) = (bx-ax)*(py-ay) - (by-ay)*(px-ax). 17-bit signed differences give 34-bit
   // products; 36 bits holds their difference without overflow.
   function automatic logic signed [35:0] edge_fn(
      input logic [15:0] ax, input logic [15:0] ay,
      input logic [15:0] bx, input logic [15:0] by,
      input logic [15:0] px, input logic [15:0] py);
      logic signed [16:0] dx_ab, dy_ap, dy_ab, dx_ap;
      logic signed [35:0] t0, t1;
      dx_ab = $signed({1'b0, bx}) - $signed({1'b0, ax});
      dy_ap = $signed({1'b0, py}) - $signed({1'b0, ay});
      dy_ab = $signed({1'b0, by}) - $signed({1'b0, ay});
      dx_ap = $signed({1'b0, px}) - $signed({1'b0, ax});
      t0 = 36'(dx_ab) * 36'(dy_ap);
      t1 = 36'(dy_ab) * 36'(dx_ap);
      return t0 - t1;
   endfunction

   // Bounding box, clamped to the screen; vertices themselves are not clamped.
   logic [15:0] xmin_c, xmax_c, ymin_c, ymax_c;
   assign xmin_c = clamp(min3(x1_q, x2_q, x3_q), XLimit);
   assign xmax_c = clamp(max3(x1_q, x2_q, x3_q), XLimit);
   assign ymin_c = clamp(min3(y1_q, y2_q, y3_q), YLimit);
   assign ymax_c = clamp(max3(y1_q, y2_q, y3_q), YLimit);

   logic signed [35:0] area_c, e0_c, e1_c, e2_c;
   assign area_c = edge_fn(x1_q, y1_q, x2_q, y2_q, x3_q, y3_q);
   assign e0_c   = edge_fn(x1_q, y1_q, x2_q, y2_q, x_q, y_q);
   assign e1_c   = edge_fn(x2_q, y2_q, x3_q, y3_q, x_q, y_q);
   assign e2_c   = edge_fn(x3_q, y3_q, x1_q, y1_q, x_q, y_q);

   logic area_zero_c;
   assign area_zero_c = (area_c == '0);

   // Accept either winding: every edge must agree in sign with the area, zero counts as inside.
   logic e0_nonpos, e1_nonpos, e2_nonpos;
   logic inside_c;
   assign e0_nonpos = e0_c[35] || (e0_c == '0);
   assign e1_nonpos = e1_c[35] || (e1_c == '0);
   assign e2_nonpos = e2_c[35] || (e2_c == '0);
   assign inside_c  = area_neg_q ? (e0_nonpos && e1_nonpos && e2_nonpos)
                                 : (!e0_c[35] && !e1_c[35] && !e2_c[35]);

   logic x_more_c, y_more_c;
   assign x_more_c = (x_q < xmax_q);
   assign y_more_c = (y_q < ymax_q);

   assign bus.pixel_number = pixel_number_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d           = state_q;
      bus.clear         = 1'b0;
      bus.count_up      = 1'b0;
      bus.next_triangle = 1'b0;
      bus.load_texture  = 1'b0;
      bus.get_rgba      = 1'b0;
      bus.get_pixel     = 1'b0;
      bus.get_line      = 1'b0;
      bus.frame_ready_o = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.opcode_received) state_d = StClear;
         end
         StClear: begin
            bus.clear = 1'b1;
            state_d   = StLoad;
         end
         StLoad: begin
            bus.load_texture = 1'b1;
            if (bus.data_ready) state_d = StSetup;
         end
         StSetup: begin
            state_d = area_zero_c ? StTriEnd : StTest;
         end
         StTest: begin
            state_d = inside_c ? StFetch : StAdvance;
         end
         StFetch: begin
            bus.get_rgba = 1'b1;
            if (bus.data_ready) state_d = StWrite;
         end
         StWrite: begin
            bus.get_pixel = 1'b1;
            bus.count_up  = 1'b1;
            state_d       = StAdvance;
         end
         StAdvance: begin
            if (x_more_c) begin
               state_d = StTest;
            end else if (y_more_c) begin
               bus.get_line = 1'b1;
               state_d      = StTest;
            end else begin
               state_d = StTriEnd;
            end
         end
         StTriEnd: begin
            bus.next_triangle = 1'b1;
            state_d           = bus.triangle_done ? StFrame : StLoad;
         end
         StFrame: begin
            bus.frame_ready_o = 1'b1;
            if (bus.frame_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x1_q           <= '0;
         y1_q           <= '0;
         x2_q           <= '0;
         y2_q           <= '0;
         x3_q           <= '0;
         y3_q           <= '0;
         xmin_q         <= '0;
         xmax_q         <= '0;
         ymin_q         <= '0;
         ymax_q         <= '0;
         x_q            <= '0;
         y_q            <= '0;
         area_neg_q     <= 1'b0;
         pixel_number_q <= '0;
      end else begin
         if (state_q == StLoad && bus.data_ready) begin
            x1_q <= bus.x1;
            y1_q <= bus.y1;
            x2_q <= bus.x2;
            y2_q <= bus.y2;
            x3_q <= bus.x3;
            y3_q <= bus.y3;
         end
         if (state_q == StSetup) begin
            xmin_q     <= xmin_c;
            xmax_q     <= xmax_c;
            ymin_q     <= ymin_c;
            ymax_q     <= ymax_c;
            x_q        <= xmin_c;
            y_q        <= ymin_c;
            area_neg_q <= area_c[35];
         end
         if (state_q == StTest) begin
            pixel_number_q <= 19'(y_q) * HResW + 19'(x_q);
         end
         if (state_q == StAdvance) begin
            if (x_more_c) begin
               x_q <= x_q + 16'd1;
            end else if (y_more_c) begin
               x_q <= xmin_q;
               y_q <= y_q + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_rasteriser_unit.sv
module tb_rasteriser_unit;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   rasteriser_unit_if bus ();

   rasteriser_unit #(
      .H_RES(640),
      .V_RES(480)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   // Output monitor, sampled mid-cycle.
   logic [18:0] pix_q[$];
   int n_count_up = 0;
   int n_line     = 0;
   int n_next     = 0;
   int n_rgba     = 0;
   int n_skew     = 0;

   always @(negedge clk) begin
      if (bus.get_pixel) pix_q.push_back(bus.pixel_number);
      if (bus.count_up) n_count_up++;
      if (bus.get_line) n_line++;
      if (bus.next_triangle) n_next++;
      if (bus.get_rgba) n_rgba++;
      if (bus.get_pixel !== bus.count_up) n_skew++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) begin
         passes++;
      end else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] out_vec();
      return 32'({bus.clear, bus.count_up, bus.next_triangle, bus.load_texture, bus.get_rgba,
                  bus.get_pixel, bus.get_line, bus.frame_ready_o});
   endfunction

   // sel 0: frame_ready_o, sel 1: get_rgba
   task automatic wait_high(input int sel, input int budget, input string tag);
      int   n;
      logic seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < budget) begin
         step();
         n++;
         seen = (sel == 0) ? bus.frame_ready_o : bus.get_rgba;
      end
      check(tag, 32'(seen), 32'd1);
   endtask

   task automatic set_tri(input logic [15:0] ax, input logic [15:0] ay, input logic [15:0] bx,
                          input logic [15:0] by, input logic [15:0] cx, input logic [15:0] cy);
      bus.x1 = ax;
      bus.y1 = ay;
      bus.x2 = bx;
      bus.y2 = by;
      bus.x3 = cx;
      bus.y3 = cy;
   endtask

   // From IDLE: one-cycle opcode, expect one clear pulse, then LOAD.
   task automatic start_frame(input string tag);
      bus.opcode_received = 1'b1;
      step();
      bus.opcode_received = 1'b0;
      check({tag, "_clear"}, 32'(bus.clear), 32'd1);
      step();
      check({tag, "_clear_once"}, 32'(bus.clear), 32'd0);
      check({tag, "_load"}, 32'(bus.load_texture), 32'd1);
   endtask

   task automatic finish_frame(input string tag);
      step();
      step();
      check({tag, "_frame_held"}, 32'(bus.frame_ready_o), 32'd1);
      bus.frame_ready = 1'b1;
      step();
      bus.frame_ready = 1'b0;
      check({tag, "_frame_idle"}, out_vec(), 32'd0);
   endtask

   int exp_small[10] = '{0, 1, 2, 3, 640, 641, 642, 1280, 1281, 1920};

   // Expects LOAD; draws one small right triangle as the last of the frame.
   task automatic run_small(input string tag);
      int          b_pix, b_cu, b_line, b_next, b_skew;
      logic [31:0] obs;
      b_pix  = pix_q.size();
      b_cu   = n_count_up;
      b_line = n_line;
      b_next = n_next;
      b_skew = n_skew;
      bus.data_ready    = 1'b1;
      bus.triangle_done = 1'b1;
      wait_high(0, 300, {tag, "_reach_frame"});
      bus.data_ready = 1'b0;
      check({tag, "_pixels"}, 32'(pix_q.size() - b_pix), 32'd10);
      for (int i = 0; i < 10; i++) begin
         if (b_pix + i < pix_q.size()) obs = 32'(pix_q[b_pix + i]);
         else obs = '1;
         check($sformatf("%s_pix%0d", tag, i), obs, 32'(exp_small[i]));
      end
      check({tag, "_count_up"}, 32'(n_count_up - b_cu), 32'd10);
      check({tag, "_get_line"}, 32'(n_line - b_line), 32'd3);
      check({tag, "_next_tri"}, 32'(n_next - b_next), 32'd1);
      check({tag, "_strobe_align"}, 32'(n_skew - b_skew), 32'd0);
      finish_frame(tag);
   endtask

   initial begin
      int          b_pix, b_rgba, b_next, bad_x, bad_y;
      logic [31:0] pmin, pmax, plast;

      reset               = 1'b1;
      bus.opcode_received = 1'b1;
      bus.frame_ready     = 1'b1;
      bus.data_ready      = 1'b1;
      bus.triangle_done   = 1'b1;
      set_tri(16'd7, 16'd9, 16'd100, 16'd3, 16'd5, 16'd200);
      step();
      bus.opcode_received = 1'b0;
      bus.data_ready      = 1'b0;
      bus.frame_ready     = 1'b0;
      step();
      check("reset_outputs", out_vec(), 32'd0);
      check("reset_pixel_number", 32'(bus.pixel_number), 32'd0);
      reset             = 1'b0;
      bus.triangle_done = 1'b0;
      step();
      check("idle_no_strobes", out_vec(), 32'd0);

      start_frame("f1");
      set_tri(16'd0, 16'd0, 16'd3, 16'd0, 16'd0, 16'd3);
      run_small("ccw");

      start_frame("f2");
      set_tri(16'd0, 16'd0, 16'd0, 16'd3, 16'd3, 16'd0);
      run_small("cw");

      // Degenerate triangle, not last: straight back to LOAD with no colour fetch.
      start_frame("f3");
      b_rgba = n_rgba;
      b_next = n_next;
      set_tri(16'd5, 16'd5, 16'd10, 16'd10, 16'd20, 16'd20);
      bus.data_ready    = 1'b1;
      bus.triangle_done = 1'b0;
      step();
      bus.data_ready = 1'b0;
      step();
      check("degen_next_tri", 32'(bus.next_triangle), 32'd1);
      step();
      check("degen_back_to_load", 32'(bus.load_texture), 32'd1);
      check("degen_no_rgba", 32'(n_rgba - b_rgba), 32'd0);
      check("degen_next_count", 32'(n_next - b_next), 32'd1);

      // Box reaches past the screen corner; all 100 clipped pixels are covered.
      b_pix = pix_q.size();
      set_tri(16'd630, 16'd470, 16'd700, 16'd470, 16'd630, 16'd500);
      bus.data_ready    = 1'b1;
      bus.triangle_done = 1'b1;
      wait_high(0, 2000, "clip_reach_frame");
      bus.data_ready = 1'b0;
      pmin  = '1;
      pmax  = '0;
      plast = '1;
      bad_x = 0;
      bad_y = 0;
      for (int i = b_pix; i < pix_q.size(); i++) begin
         if (32'(pix_q[i]) < pmin) pmin = 32'(pix_q[i]);
         if (32'(pix_q[i]) > pmax) pmax = 32'(pix_q[i]);
         if ((32'(pix_q[i]) % 640) < 630) bad_x++;
         if ((32'(pix_q[i]) / 640) < 470 || (32'(pix_q[i]) / 640) > 479) bad_y++;
         plast = 32'(pix_q[i]);
      end
      check("clip_pixels", 32'(pix_q.size() - b_pix), 32'd100);
      check("clip_min", pmin, 32'd301430);
      check("clip_max", pmax, 32'd307199);
      check("clip_last", plast, 32'd307199);
      check("clip_x_range", 32'(bad_x), 32'd0);
      check("clip_y_range", 32'(bad_y), 32'd0);
      finish_frame("clip");

      // Reset while waiting for colour aborts back to IDLE.
      start_frame("f5");
      set_tri(16'd2, 16'd1, 16'd5, 16'd1, 16'd2, 16'd4);
      bus.data_ready = 1'b1;
      step();
      bus.data_ready = 1'b0;
      wait_high(1, 20, "abort_reach_fetch");
      step();
      check("abort_fetch_held", 32'(bus.get_rgba), 32'd1);
      check("abort_fetch_pixel", 32'(bus.pixel_number), 32'd642);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("abort_rgba_low", 32'(bus.get_rgba), 32'd0);
      check("abort_outputs", out_vec(), 32'd0);
      check("abort_pixel_number", 32'(bus.pixel_number), 32'd0);
      step();
      check("abort_stays_idle", out_vec(), 32'd0);
      start_frame("f6");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
